// File: rtl/steer_en_dp_if.sv
`default_nettype none
// ============================================================================
//  Module      : steer_en_dp_if
//  Description : Bundle between the load-cell front end / steering-enable SM
//                and the steering-enable datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface steer_en_dp_if;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        vld;
    logic        clr_tmr;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        tmr_full;

    // Drives samples and timer clear, observes the flags
    modport master (
        output lft_ld, rght_ld, vld, clr_tmr,
        input  sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full
    );

    // The datapath itself
    modport slave (
        input  lft_ld, rght_ld, vld, clr_tmr,
        output sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full
    );
endinterface
`default_nettype wire

// File: rtl/steer_en_dp.sv
`default_nettype none
// ============================================================================
//  Module      : steer_en_dp
//  Description : Steering-enable datapath. Captures left/right load-cell
//                samples, registers sum/difference comparison flags and runs
//                the rider-settle timer.
//                Optional macro STEER_FAST_SIM_EN shortens the timer terminal
//                count to 32767 for simulation (comparisons unaffected).
//  Revision    : 1.0 - initial release
// ============================================================================
module steer_en_dp #(
    parameter logic [12:0] MIN_RIDER_WT = 13'h200,
    parameter logic [12:0] HYST         = 13'h040,
    parameter logic [25:0] TMR_FULL_CNT = 26'd64999999
) (
    input  wire          clk,
    input  wire          rst,
    steer_en_dp_if.slave bus
);

`ifdef STEER_FAST_SIM_EN
    localparam logic [25:0] c_TERM_CNT = 26'd32767;
`else
    localparam logic [25:0] c_TERM_CNT = TMR_FULL_CNT;
`endif

    localparam logic [12:0] c_THR_HI = MIN_RIDER_WT + HYST;
    localparam logic [12:0] c_THR_LO = MIN_RIDER_WT - HYST;

    logic [11:0] r_lft;
    logic [11:0] r_rght;
    logic        r_vld_d;
    logic        r_sum_gt_min;
    logic        r_sum_lt_min;
    logic        r_diff_gt_1_4;
    logic        r_diff_gt_15_16;
    logic [25:0] r_tmr;

    logic [12:0] w_sum;
    logic [11:0] w_diff;
    logic [12:0] w_sum_qtr;
    logic [12:0] w_sum_15_16;

    // Stage 1: latch the sample pair and remember that a new pair arrived
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lft   <= 12'd0;
            r_rght  <= 12'd0;
            r_vld_d <= 1'b0;
        end else begin
            r_vld_d <= bus.vld;
            if (bus.vld) begin
                r_lft  <= bus.lft_ld;
                r_rght <= bus.rght_ld;
            end
        end
    end

    // Sum/difference arithmetic on the captured pair; diff is larger minus smaller
    always_comb begin
        w_sum       = {1'b0, r_lft} + {1'b0, r_rght};
        w_diff      = (r_lft >= r_rght) ? (r_lft - r_rght) : (r_rght - r_lft);
        w_sum_qtr   = w_sum >> 2;
        w_sum_15_16 = w_sum - (w_sum >> 4);
    end

    // Stage 2: flags follow the captured pair one cycle after capture, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_gt_min    <= 1'b0;
            r_sum_lt_min    <= 1'b1;
            r_diff_gt_1_4   <= 1'b0;
            r_diff_gt_15_16 <= 1'b0;
        end else if (r_vld_d) begin
            r_sum_gt_min    <= (w_sum > c_THR_HI);
            r_sum_lt_min    <= (w_sum < c_THR_LO);
            r_diff_gt_1_4   <= ({1'b0, w_diff} > w_sum_qtr);
            r_diff_gt_15_16 <= ({1'b0, w_diff} > w_sum_15_16);
        end
    end

    // Settle timer: clear has priority, otherwise count up and saturate
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr <= 26'd0;
        end else if (bus.clr_tmr) begin
            r_tmr <= 26'd0;
        end else if (r_tmr != c_TERM_CNT) begin
            r_tmr <= r_tmr + 26'd1;
        end
    end

    assign bus.sum_gt_min    = r_sum_gt_min;
    assign bus.sum_lt_min    = r_sum_lt_min;
    assign bus.diff_gt_1_4   = r_diff_gt_1_4;
    assign bus.diff_gt_15_16 = r_diff_gt_15_16;
    assign bus.tmr_full      = (r_tmr == c_TERM_CNT);

endmodule
`default_nettype wire

// File: tb/tb_steer_en_dp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_steer_en_dp
//  Description : Directed self-checking bench for steer_en_dp. The timer
//                terminal count is forced to 32767 in both build variants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_steer_en_dp;

    localparam int c_TERM = 32767;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] w_flags;

    always #10 clk = ~clk;

    steer_en_dp_if sif ();

    steer_en_dp #(
        .TMR_FULL_CNT (26'd32767)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    // {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16}
    assign w_flags = {sif.sum_gt_min, sif.sum_lt_min, sif.diff_gt_1_4, sif.diff_gt_15_16};

    // One vld strobe, then wait until the flags should reflect it
    task automatic drive_sample(input logic [11:0] l, input logic [11:0] r);
        @(negedge clk);
        sif.lft_ld  = l;
        sif.rght_ld = r;
        sif.vld     = 1'b1;
        @(negedge clk);
        sif.vld     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (w_flags !== 4'b0100) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0100", w_flags);
        end
        checks++;
        if (sif.tmr_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_tmr_full: got %b want 0", sif.tmr_full);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sum_band();
        logic [11:0] l [8] = '{12'h150, 12'h120, 12'h121, 12'h0E0, 12'h0E0, 12'h0F8, 12'h000, 12'hFFF};
        logic [11:0] r [8] = '{12'h150, 12'h120, 12'h120, 12'h0E0, 12'h0DF, 12'h0F8, 12'h000, 12'hFFF};
        logic [3:0]  e [8] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            drive_sample(l[i], r[i]);
            checks++;
            if (w_flags !== e[i]) begin
                errors++;
                $display("FAIL sum_band[%0d] l=%h r=%h: got %b want %b", i, l[i], r[i], w_flags, e[i]);
            end
        end
    endtask

    task automatic test_diff();
        logic [11:0] l [7] = '{12'h200, 12'h300, 12'h010, 12'h0F0, 12'h180, 12'h0A0, 12'h0A1};
        logic [11:0] r [7] = '{12'h080, 12'h000, 12'h300, 12'h000, 12'h100, 12'h060, 12'h060};
        logic [3:0]  e [7] = '{4'b1010, 4'b1011, 4'b1011, 4'b0111, 4'b1000, 4'b0100, 4'b0110};
        for (int i = 0; i < 7; i++) begin
            drive_sample(l[i], r[i]);
            checks++;
            if (w_flags !== e[i]) begin
                errors++;
                $display("FAIL diff[%0d] l=%h r=%h: got %b want %b", i, l[i], r[i], w_flags, e[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive_sample(12'h0F8, 12'h0F8);
        checks++;
        if (w_flags !== 4'b0000) begin
            errors++;
            $display("FAIL hold_setup: got %b want 0000", w_flags);
        end
        @(negedge clk);
        sif.lft_ld  = 12'hFFF;
        sif.rght_ld = 12'h000;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (w_flags !== 4'b0000) begin
            errors++;
            $display("FAIL hold_100: got %b want 0000", w_flags);
        end
    endtask

    task automatic test_latency();
        drive_sample(12'h300, 12'h000);
        @(negedge clk);
        sif.lft_ld  = 12'h000;
        sif.rght_ld = 12'h000;
        sif.vld     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (w_flags !== 4'b1011) begin
            errors++;
            $display("FAIL latency_early: got %b want 1011", w_flags);
        end
        @(negedge clk);
        sif.vld = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (w_flags !== 4'b0100) begin
            errors++;
            $display("FAIL latency_due: got %b want 0100", w_flags);
        end
    endtask

    task automatic test_reset_dominates();
        drive_sample(12'h300, 12'h000);
        @(negedge clk);
        rst         = 1'b1;
        sif.vld     = 1'b1;
        sif.lft_ld  = 12'h300;
        @(posedge clk);
        #1;
        checks++;
        if (w_flags !== 4'b0100) begin
            errors++;
            $display("FAIL rst_dom_flags: got %b want 0100", w_flags);
        end
        @(negedge clk);
        rst     = 1'b0;
        sif.vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (w_flags !== 4'b0100) begin
            errors++;
            $display("FAIL rst_dom_after: got %b want 0100", w_flags);
        end
    endtask

    // Count from a zero count: low after TERM-1 edges, high after TERM edges
    task automatic timer_run(input string tag);
        repeat (c_TERM - 1) @(posedge clk);
        #1;
        checks++;
        if (sif.tmr_full !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: got %b want 0", tag, sif.tmr_full);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sif.tmr_full !== 1'b1) begin
            errors++;
            $display("FAIL %s_full: got %b want 1", tag, sif.tmr_full);
        end
    endtask

    task automatic test_timer();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        timer_run("tmr_from_rst");
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (sif.tmr_full !== 1'b1) begin
            errors++;
            $display("FAIL tmr_saturate: got %b want 1", sif.tmr_full);
        end
        @(negedge clk);
        sif.clr_tmr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sif.tmr_full !== 1'b0) begin
            errors++;
            $display("FAIL tmr_clear: got %b want 0", sif.tmr_full);
        end
        @(negedge clk);
        sif.clr_tmr = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        checks++;
        if (sif.tmr_full !== 1'b0) begin
            errors++;
            $display("FAIL tmr_restart: got %b want 0", sif.tmr_full);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        timer_run("tmr_after_rst");
    endtask

    initial begin
        rst         = 1'b1;
        sif.lft_ld  = 12'h000;
        sif.rght_ld = 12'h000;
        sif.vld     = 1'b0;
        sif.clr_tmr = 1'b0;
        test_reset();
        test_sum_band();
        test_diff();
        test_hold();
        test_latency();
        test_reset_dominates();
        test_timer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
